// File: rtl/hazard_pkg.sv
// Shared encodings and hazard-cause bundle for the pipeline hazard scoreboard.
package hazard_pkg;
  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_W       = 2'b01;
  localparam logic [1:0] FWD_M       = 2'b10;
  localparam logic [1:0] RF_SEL_LOAD = 2'b01;

  typedef struct packed {
    logic load_use;
    logic raw_mc;
    logic waw_mc;
    logic structural;
    logic redirect;
  } hazard_t;
endpackage

// File: rtl/pipeline_hazard_scoreboard_if.sv
// Pipeline <-> hazard unit signal bundle; master is the pipeline, slave the hazard unit.
interface pipeline_hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] rs1_D, rs2_D, rd_D;
  logic              regWrite_D;
  logic [REG_AW-1:0] rs1_E, rs2_E, rd_E;
  logic [1:0]        rf_wr_sel_E;
  logic              pcSource_E;
  logic              mc_start_E;
  logic              mc_done;
  logic [REG_AW-1:0] rd_M, rd_W;
  logic              regWrite_M, regWrite_W;
  logic [1:0]        forwardA_E, forwardB_E;
  logic              stall_F, stall_D, stall_E;
  logic              flush_D, flush_E, flush_M;
  logic              mc_busy, mc_err;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output rs1_D, rs2_D, rd_D, regWrite_D, rs1_E, rs2_E, rd_E, rf_wr_sel_E,
           pcSource_E, mc_start_E, mc_done, rd_M, rd_W, regWrite_M, regWrite_W,
    input  forwardA_E, forwardB_E, stall_F, stall_D, stall_E,
           flush_D, flush_E, flush_M, mc_busy, mc_err, stall_cycles
  );

  modport slave (
    input  rs1_D, rs2_D, rd_D, regWrite_D, rs1_E, rs2_E, rd_E, rf_wr_sel_E,
           pcSource_E, mc_start_E, mc_done, rd_M, rd_W, regWrite_M, regWrite_W,
    output forwardA_E, forwardB_E, stall_F, stall_D, stall_E,
           flush_D, flush_E, flush_M, mc_busy, mc_err, stall_cycles
  );
endinterface

// File: rtl/mc_scoreboard.sv
// Single-entry multi-cycle op tracker: pending destination, busy flag and sticky timeout.
module mc_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int MC_TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              mc_start,
  input  logic              mc_done,
  input  logic [REG_AW-1:0] rd,
  output logic              busy_q,
  output logic [REG_AW-1:0] pend_rd_q,
  output logic              mc_err
);
  localparam int TW = $clog2(MC_TIMEOUT + 1);

  logic [TW-1:0] to_cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_q    <= 1'b0;
      pend_rd_q <= '0;
      to_cnt_q  <= '0;
      mc_err    <= 1'b0;
    end else begin
      // A start while busy is a structural stall upstream, so it is simply not accepted here.
      if (!busy_q) begin
        if (mc_start) begin
          busy_q    <= 1'b1;
          pend_rd_q <= rd;
        end
      end else if (mc_done) begin
        busy_q <= 1'b0;
      end

      if (!busy_q)
        to_cnt_q <= '0;
      else if (to_cnt_q != TW'(MC_TIMEOUT))
        to_cnt_q <= to_cnt_q + TW'(1);

      if (busy_q && to_cnt_q == TW'(MC_TIMEOUT - 1))
        mc_err <= 1'b1;
    end
  end
endmodule

// File: rtl/pipeline_hazard_scoreboard.sv
// Forwarding, load-use / multi-cycle / structural stall and flush control for a 5-stage pipe.
module pipeline_hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  pipeline_hazard_scoreboard_if.slave   hz
);
  logic              busy_q;
  logic [REG_AW-1:0] pend_rd_q;
  logic              mc_err;
  logic [CNT_W-1:0]  stall_cycles_q;
  hazard_t           hc;
  logic              dep_stall;

  mc_scoreboard #(.REG_AW(REG_AW), .MC_TIMEOUT(MC_TIMEOUT)) u_sb (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .mc_start  (hz.mc_start_E),
    .mc_done   (hz.mc_done),
    .rd        (hz.rd_E),
    .busy_q    (busy_q),
    .pend_rd_q (pend_rd_q),
    .mc_err    (mc_err)
  );

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] rd_m, input logic wr_m,
    input logic [REG_AW-1:0] rd_w, input logic wr_w
  );
    if (wr_m && src != '0 && src == rd_m) return FWD_M;
    if (wr_w && src != '0 && src == rd_w) return FWD_W;
    return FWD_RF;
  endfunction

  assign hz.forwardA_E = fwd_sel(hz.rs1_E, hz.rd_M, hz.regWrite_M, hz.rd_W, hz.regWrite_W);
  assign hz.forwardB_E = fwd_sel(hz.rs2_E, hz.rd_M, hz.regWrite_M, hz.rd_W, hz.regWrite_W);

  always_comb begin
    hc            = '0;
    hc.load_use   = hz.rf_wr_sel_E == RF_SEL_LOAD && hz.rd_E != '0 &&
                    (hz.rd_E == hz.rs1_D || hz.rd_E == hz.rs2_D);
    hc.raw_mc     = busy_q && pend_rd_q != '0 &&
                    (pend_rd_q == hz.rs1_D || pend_rd_q == hz.rs2_D);
    hc.waw_mc     = busy_q && hz.regWrite_D && pend_rd_q != '0 && hz.rd_D == pend_rd_q;
    hc.structural = hz.mc_start_E && busy_q;
    hc.redirect   = hz.pcSource_E;
  end

  // A taken redirect kills the decode instruction, so its dependencies no longer matter.
  assign dep_stall  = hc.load_use | hc.raw_mc | hc.waw_mc | hc.structural;
  assign hz.stall_F = dep_stall & ~hc.redirect;
  assign hz.stall_D = dep_stall & ~hc.redirect;
  assign hz.stall_E = hc.structural;
  assign hz.flush_D = hc.redirect;
  assign hz.flush_E = hc.load_use | hc.raw_mc | hc.waw_mc | hc.redirect;
  assign hz.flush_M = hc.structural;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      stall_cycles_q <= '0;
    else if (hz.stall_F && stall_cycles_q != '1)
      stall_cycles_q <= stall_cycles_q + CNT_W'(1);
  end

  assign hz.mc_busy      = busy_q;
  assign hz.mc_err       = mc_err;
  assign hz.stall_cycles = stall_cycles_q;
endmodule
